// File: rtl/fpu_addsub_align_pkg.sv
// Shared widths, constants and payload types for the FPU add/sub alignment stage.
// FPU_ALIGN_FLUSH_DENORM_EN: when defined, subnormal operands unpack as signed zero.
package fpu_addsub_align_pkg;

    localparam int unsigned NORMALIZE_MANTISSA_LENGTH = 27;
    localparam int unsigned MAN_W    = NORMALIZE_MANTISSA_LENGTH;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned GRS_W    = 3;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * EXP_BIAS + 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fpu_unpacked_t;

    typedef struct packed {
        logic [EXP_W-1:0] exp_x;
        logic [EXP_W-1:0] shamt;
        logic [MAN_W-1:0] man_x;
        logic [MAN_W-1:0] man_y;
        logic             sign_x;
        logic             sign_y;
        logic             add_sub;
        logic             swap;
        logic             sign_a;
        logic             sign_b_eff;
        logic             cancel;
        logic             special;
        logic [31:0]      special_result;
    } align_s1_t;

    // Effective exponent is 1 for exp==0 so subnormals line up with the smallest normals.
    function automatic fpu_unpacked_t fpu_unpack(input logic [31:0] op);
        fpu_unpacked_t    u;
        logic [EXP_W-1:0] e;
        logic [FRAC_W-1:0] f;
        logic             hidden;
        e = op[30:23];
        f = op[22:0];
`ifdef FPU_ALIGN_FLUSH_DENORM_EN
        if (e == '0) f = '0;
`endif
        hidden = (e != '0);
        u.sign = op[31];
        u.exp  = hidden ? e : EXP_W'(1);
        u.man  = {hidden, f, GRS_W'(0)};
        return u;
    endfunction

endpackage

// File: rtl/fpu_addsub_align_shifter.sv
// Combinational right barrel shift of the smaller mantissa with sticky collection in bit 0.
module fpu_align_shifter
    import fpu_addsub_align_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic [EXP_W-1:0] shamt_i,
    output logic [MAN_W-1:0] man_o
);

    logic [MAN_W-1:0] shifted;
    logic [MAN_W-1:0] lost_mask;
    logic             sticky;

    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        man_o     = '0;
        if (shamt_i >= EXP_W'(MAN_W)) begin
            sticky = |man_i;
            man_o  = {{(MAN_W-1){1'b0}}, sticky};
        end else begin
            shifted   = man_i >> shamt_i;
            lost_mask = ~({MAN_W{1'b1}} << shamt_i);
            sticky    = |(man_i & lost_mask);
            man_o     = {shifted[MAN_W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fpu_addsub_align.sv
// FPU add/sub pre-adder alignment: unpack/compare/swap (stage 1), align shift (stage 2).
// Optional FPU_ALIGN_FLUSH_DENORM_EN flushes subnormal inputs to signed zero.
module fpu_addsub_align
    import fpu_addsub_align_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             add_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] man_x,
    output logic [MAN_W-1:0] man_y,
    output logic             sign_x,
    output logic             sign_y,
    output logic             add_sub_o,
    output logic [EXP_W-1:0] exp_o,
    output logic             sign_res,
    output logic             special,
    output logic [31:0]      special_result
);

    fpu_unpacked_t          ua, ub;
    logic                   sb_eff;
    logic                   a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
    logic                   swap;
    align_s1_t              s1_d, s1_q;
    logic                   s1_valid_q, s2_valid_q;
    logic                   s1_adv, s2_adv;
    logic [MAN_W-1:0]       man_y_d;
    logic                   sign_res_d;

    logic [MAN_W-1:0]       man_x_q, man_y_q;
    logic                   sign_x_q, sign_y_q, add_sub_q, sign_res_q, special_q;
    logic [EXP_W-1:0]       exp_q;
    logic [31:0]            special_result_q;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: unpack, magnitude compare, swap, special-case detection.
    always_comb begin
        ua     = fpu_unpack(op_a);
        ub     = fpu_unpack(op_b);
        sb_eff = ub.sign ^ add_sub;
        a_nan  = (op_a[30:23] == EXP_MAX) && (op_a[22:0] != '0);
        b_nan  = (op_b[30:23] == EXP_MAX) && (op_b[22:0] != '0);
        a_inf  = (op_a[30:23] == EXP_MAX) && (op_a[22:0] == '0);
        b_inf  = (op_b[30:23] == EXP_MAX) && (op_b[22:0] == '0);
        mag_a  = {ua.exp, ua.man};
        mag_b  = {ub.exp, ub.man};
        swap   = (mag_b > mag_a);

        s1_d            = '0;
        s1_d.exp_x      = swap ? ub.exp : ua.exp;
        s1_d.shamt      = swap ? (ub.exp - ua.exp) : (ua.exp - ub.exp);
        s1_d.man_x      = swap ? ub.man : ua.man;
        s1_d.man_y      = swap ? ua.man : ub.man;
        s1_d.sign_x     = swap ? ub.sign : ua.sign;
        s1_d.sign_y     = swap ? ua.sign : ub.sign;
        s1_d.add_sub    = add_sub;
        s1_d.swap       = swap;
        s1_d.sign_a     = ua.sign;
        s1_d.sign_b_eff = sb_eff;
        s1_d.cancel     = (mag_a == mag_b) && (ua.sign != sb_eff);

        if (a_nan || b_nan) begin
            s1_d.special        = 1'b1;
            s1_d.special_result = QNAN;
        end else if (a_inf && b_inf) begin
            s1_d.special        = 1'b1;
            s1_d.special_result = (ua.sign != sb_eff) ? QNAN : {ua.sign, EXP_MAX, FRAC_W'(0)};
        end else if (a_inf) begin
            s1_d.special        = 1'b1;
            s1_d.special_result = {ua.sign, EXP_MAX, FRAC_W'(0)};
        end else if (b_inf) begin
            s1_d.special        = 1'b1;
            s1_d.special_result = {sb_eff, EXP_MAX, FRAC_W'(0)};
        end
    end

    fpu_align_shifter u_shifter (
        .man_i   (s1_q.man_y),
        .shamt_i (s1_q.shamt),
        .man_o   (man_y_d)
    );

    // Exact cancellation yields +0 in round-to-nearest, so its sign is forced low.
    always_comb begin
        sign_res_d = s1_q.swap ? s1_q.sign_b_eff : s1_q.sign_a;
        if (s1_q.cancel) sign_res_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q       <= 1'b0;
            s2_valid_q       <= 1'b0;
            s1_q             <= '0;
            man_x_q          <= '0;
            man_y_q          <= '0;
            sign_x_q         <= 1'b0;
            sign_y_q         <= 1'b0;
            add_sub_q        <= 1'b0;
            exp_q            <= '0;
            sign_res_q       <= 1'b0;
            special_q        <= 1'b0;
            special_result_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    man_x_q          <= s1_q.man_x;
                    man_y_q          <= man_y_d;
                    sign_x_q         <= s1_q.sign_x;
                    sign_y_q         <= s1_q.sign_y;
                    add_sub_q        <= s1_q.add_sub;
                    exp_q            <= s1_q.exp_x;
                    sign_res_q       <= sign_res_d;
                    special_q        <= s1_q.special;
                    special_result_q <= s1_q.special_result;
                end
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign man_x          = man_x_q;
    assign man_y          = man_y_q;
    assign sign_x         = sign_x_q;
    assign sign_y         = sign_y_q;
    assign add_sub_o      = add_sub_q;
    assign exp_o          = exp_q;
    assign sign_res       = sign_res_q;
    assign special        = special_q;
    assign special_result = special_result_q;

endmodule

// File: tb/tb_fpu_addsub_align.sv
// Scoreboard bench for fpu_addsub_align: directed vectors, backpressure and mid-stream reset.
module tb_fpu_addsub_align;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, add_sub, out_valid, out_ready;
    logic        sign_x, sign_y, add_sub_o, sign_res, special;
    logic [31:0] op_a, op_b, special_result;
    logic [26:0] man_x, man_y;
    logic [7:0]  exp_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [26:0] mx;
        logic [26:0] my;
        logic        sx;
        logic        sy;
        logic        asb;
        logic [7:0]  e;
        logic        sr;
        logic        sp;
        logic [31:0] sres;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic        hold_prev = 1'b0;
    logic [98:0] snap;
    logic [98:0] bus;

    fpu_addsub_align dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .add_sub        (add_sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .man_x          (man_x),
        .man_y          (man_y),
        .sign_x         (sign_x),
        .sign_y         (sign_y),
        .add_sub_o      (add_sub_o),
        .exp_o          (exp_o),
        .sign_res       (sign_res),
        .special        (special),
        .special_result (special_result)
    );

    always #5 clk = ~clk;

    assign bus = {man_x, man_y, sign_x, sign_y, add_sub_o, exp_o, sign_res, special, special_result};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [26:0] mx, input logic [26:0] my,
                                input logic sx, input logic sy, input logic asb, input logic [7:0] e,
                                input logic sr, input logic sp, input logic [31:0] sres);
        exp_t x;
        x.name = n; x.mx = mx; x.my = my; x.sx = sx; x.sy = sy; x.asb = asb;
        x.e = e; x.sr = sr; x.sp = sp; x.sres = sres;
        return x;
    endfunction

    // Monitor: output stability under stall, then pop-and-compare on each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && out_valid) check("hold_stable", 128'(bus), 128'(snap));
            hold_prev = out_valid && !out_ready;
            snap      = bus;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got output %0h with empty scoreboard, want none", bus);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.name, "_special"}, 128'(special), 128'(mon_e.sp));
                    if (mon_e.sp)
                        check({mon_e.name, "_result"}, 128'(special_result), 128'(mon_e.sres));
                    else
                        check({mon_e.name, "_data"},
                              128'({man_x, man_y, sign_x, sign_y, add_sub_o, exp_o, sign_res}),
                              128'({mon_e.mx, mon_e.my, mon_e.sx, mon_e.sy, mon_e.asb, mon_e.e, mon_e.sr}));
                end
            end
        end
    end

    // Called and returns at a negedge; leaves in_valid high for back-to-back issue.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t ex);
        int n = 0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        add_sub  = ex.asb;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: in_ready stuck at 0 after %0d cycles, want 1", ex.name, n);
        end else begin
            exp_q.push_back(ex);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2 out_ready = r;
        @(negedge clk);
    endtask

    exp_t e_one, e_sub, e_swp, e_d24, e_d30, e_cnc, e_iin, e_nan, e_inf;

    initial begin
        e_one = mk("one_plus_one", 27'h4000000, 27'h4000000, 0, 0, 0, 8'd127, 0, 0, 32'h0);
        e_sub = mk("sub_noswap",   27'h6000000, 27'h1000000, 0, 0, 1, 8'd127, 0, 0, 32'h0);
        e_swp = mk("sub_swap",     27'h6000000, 27'h1000000, 0, 0, 1, 8'd127, 1, 0, 32'h0);
        e_d24 = mk("shift_d24",    27'h4000000, 27'h0000005, 0, 0, 0, 8'd151, 0, 0, 32'h0);
        e_d30 = mk("shift_d30",    27'h4000000, 27'h0000001, 0, 0, 0, 8'd157, 0, 0, 32'h0);
        e_cnc = mk("neg_cancel",   27'h6000000, 27'h6000000, 1, 1, 1, 8'd127, 0, 0, 32'h0);
        e_iin = mk("inf_m_inf",    27'h0, 27'h0, 0, 0, 1, 8'd0, 0, 1, 32'h7FC00000);
        e_nan = mk("nan_in",       27'h0, 27'h0, 0, 0, 0, 8'd0, 0, 1, 32'h7FC00000);
        e_inf = mk("one_m_inf",    27'h0, 27'h0, 0, 0, 1, 8'd0, 0, 1, 32'hFF800000);

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; add_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_data",      128'(bus),       128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        send(32'h3F800000, 32'h3F800000, e_one);
        send(32'h3FC00000, 32'h3E800000, e_sub);
        send(32'h3E800000, 32'h3FC00000, e_swp);
        send(32'h4B800000, 32'h3F800001, e_d24);
        send(32'h4E800000, 32'h3F800001, e_d30);
        send(32'hBFC00000, 32'hBFC00000, e_cnc);
        send(32'h7F800000, 32'h7F800000, e_iin);
        send(32'h7FC00000, 32'h3F800000, e_nan);
        send(32'h3F800000, 32'h7F800000, e_inf);
        in_valid = 1'b0;
        drain();

        // Backpressure: two fill the pipe, the third waits until the stall is released.
        set_ready(1'b0);
        send(32'h3F800000, 32'h3F800000, e_one);
        send(32'h3FC00000, 32'h3E800000, e_sub);
        fork
            send(32'h3E800000, 32'h3FC00000, e_swp);
            begin
                check("bp_in_ready_low", 128'(in_ready), 128'(0));
                check("bp_out_valid",    128'(out_valid), 128'(1));
                repeat (3) @(negedge clk);
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // Reset with a stalled, full pipe must drop everything at once.
        set_ready(1'b0);
        send(32'h4B800000, 32'h3F800001, e_d24);
        send(32'h3F800000, 32'h3F800000, e_one);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_in_ready",  128'(in_ready),  128'(1));
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 128'(out_valid), 128'(0));
        send(32'h3FC00000, 32'h3E800000, e_sub);
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
